// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
);
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_ack;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_ack;
  logic [DATA_W-1:0] r1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_ack, r0_rdata, r1_ack, r1_rdata,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_ack, r0_rdata, r1_ack, r1_rdata,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer for the single-port data memory
// Optional grant/conflict counters enabled by ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 101,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
`ifdef ARB_STATS_EN
  output logic [15:0] stat_g0,
  output logic [15:0] stat_g1,
  output logic [15:0] stat_conf,
`endif
  dmem_arbiter_if.slave bus
);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              lat_we;
  logic              lat_id;
  logic              lat_in_range;
  logic              last_grant;
  logic              mem_we_q;

  logic              elig0, elig1, any_elig, win_id, win_we, win_in_range;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [DATA_W-1:0] rd_val;
  logic              arb_point;

  // The port acked in RESP is excluded so a re-request cannot starve the other port.
  always_comb begin
    elig0 = bus.r0_req;
    elig1 = bus.r1_req;
    if (state == RESP) begin
      if (lat_id) elig1 = 1'b0;
      else        elig0 = 1'b0;
    end
    any_elig = elig0 | elig1;
    if (elig0 && elig1) win_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    else                win_id = elig1;
    win_addr     = win_id ? bus.r1_addr  : bus.r0_addr;
    win_we       = win_id ? bus.r1_we    : bus.r0_we;
    win_wdata    = win_id ? bus.r1_wdata : bus.r0_wdata;
    win_in_range = (win_addr < DEPTH_A);
    rd_val       = (lat_we || !lat_in_range) ? '0 : bus.mem_rdata;
    arb_point    = (state == IDLE) || (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.r0_ack    <= 1'b0;
      bus.r1_ack    <= 1'b0;
      bus.r0_rdata  <= '0;
      bus.r1_rdata  <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      last_grant    <= 1'b1;
      lat_we        <= 1'b0;
      lat_id        <= 1'b0;
      lat_in_range  <= 1'b0;
      mem_we_q      <= 1'b0;
    end else begin
      bus.r0_ack <= 1'b0;
      bus.r1_ack <= 1'b0;
      mem_we_q   <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (any_elig) begin
            bus.mem_addr  <= win_addr;
            bus.mem_wdata <= win_wdata;
            lat_we        <= win_we;
            lat_id        <= win_id;
            lat_in_range  <= win_in_range;
            last_grant    <= win_id;
            mem_we_q      <= win_we & win_in_range;
            state         <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (lat_id) begin
            bus.r1_rdata <= rd_val;
            bus.r1_ack   <= 1'b1;
          end else begin
            bus.r0_rdata <= rd_val;
            bus.r0_ack   <= 1'b1;
          end
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated combinationally so a reset landing in ACCESS suppresses that cycle's write.
  assign bus.mem_we = mem_we_q & ~reset;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_g0   <= '0;
      stat_g1   <= '0;
      stat_conf <= '0;
    end else if (arb_point && any_elig) begin
      if (!win_id && stat_g0 != 16'hFFFF) stat_g0 <= stat_g0 + 16'd1;
      if (win_id && stat_g1 != 16'hFFFF)  stat_g1 <= stat_g1 + 16'd1;
      if (elig0 && elig1 && stat_conf != 16'hFFFF) stat_conf <= stat_conf + 16'd1;
    end
  end
`endif
endmodule
